// File: rtl/vlc_bit_reader.sv
// Variable-length bit extractor: packs 16-bit words into a 32-bit left-aligned buffer
// and returns 1..16-bit codewords on request. Define VLC_BIT_READER_PEEK_EN to add peek_bits.
module vlc_bit_reader #(
  parameter int unsigned IN_W    = 16,
  parameter int unsigned MAX_LEN = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      req_len,
  input  logic            req_valid,
  output logic            req_ready,
  output logic [IN_W-1:0] out_bits,
  output logic [4:0]      out_len,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      fill_level,
  output logic            err
`ifdef VLC_BIT_READER_PEEK_EN
  ,
  output logic [IN_W-1:0] peek_bits
`endif
);

  localparam int unsigned BUF_W  = 2 * IN_W;
  localparam int unsigned LEN_W  = 5;
  localparam int unsigned FILL_W = 6;

  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [IN_W-1:0]   out_bits_q, out_bits_d;
  logic [LEN_W-1:0]  out_len_q, out_len_d;
  logic              out_valid_q, out_valid_d;
  logic              err_q, err_d;

  logic              req_legal;
  logic              in_acc;
  logic              req_acc;
  logic [LEN_W-1:0]  cons;
  logic [BUF_W-1:0]  rem;
  logic [FILL_W-1:0] fill_rem;

  // Handshakes, buffer consume/append and result capture.
  always_comb begin
    req_legal = (req_len != '0) && ({1'b0, req_len} <= FILL_W'(MAX_LEN));
    in_ready  = (fill_q <= FILL_W'(IN_W)) && !flush;
    // Illegal lengths bypass the fill check so they can always be reported.
    req_ready = (!out_valid_q || out_ready) && !flush &&
                (!req_legal || (fill_q >= {1'b0, req_len}));
    in_acc    = in_valid && in_ready;
    req_acc   = req_valid && req_ready;

    cons      = (req_acc && req_legal) ? req_len : '0;
    rem       = buf_q << cons;
    fill_rem  = fill_q - {1'b0, cons};

    buf_d       = rem;
    fill_d      = fill_rem;
    out_bits_d  = out_bits_q;
    out_len_d   = out_len_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;

    if (in_acc) begin
      buf_d  = rem | ({in_data, {IN_W{1'b0}}} >> fill_rem);
      fill_d = fill_rem + FILL_W'(IN_W);
    end

    if (flush) begin
      buf_d  = '0;
      fill_d = '0;
    end

    if (req_acc) begin
      out_valid_d = 1'b1;
      if (req_legal) begin
        out_bits_d = IN_W'(buf_q >> (FILL_W'(BUF_W) - {1'b0, req_len}));
        out_len_d  = req_len;
      end else begin
        out_bits_d = '0;
        out_len_d  = '0;
        err_d      = 1'b1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q       <= '0;
      fill_q      <= '0;
      out_bits_q  <= '0;
      out_len_q   <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      out_bits_q  <= out_bits_d;
      out_len_q   <= out_len_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign out_bits   = out_bits_q;
  assign out_len    = out_len_q;
  assign out_valid  = out_valid_q;
  assign fill_level = fill_q;
  assign err        = err_q;

`ifdef VLC_BIT_READER_PEEK_EN
  // Bits below fill_level are always zero, so the top half needs no masking.
  assign peek_bits = buf_q[BUF_W-1 -: IN_W];
`endif

endmodule
